rvfi_check_scheduler: RTL

RVFI_CHECK_SCHEDULER -- requirements
Module: rvfi_check_scheduler

---
 rtl/rvfi_sched_pkg.sv | 22 ++
 rtl/rvfi_chan_prio_enc.sv | 25 ++
 rtl/rvfi_check_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rvfi_sched_pkg.sv
// Shared types and constants for the RVFI check scheduler.
// Holds the sequence state encoding, order/slice widths and channel index sizing.
package rvfi_sched_pkg;

  localparam int ORDER_W      = 64;
  localparam int CHAN_SLICE_W = ORDER_W;
  // Wide enough for the largest RESET_CYCLES, RUN_CYCLES and MAX_WAIT values.
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_ARM,
    ST_FIRE_DONE
  } sched_state_e;

  function automatic int chan_idx_w(input int nret);
    return (nret > 1) ? $clog2(nret) : 1;
  endfunction

endpackage

// File: rtl/rvfi_chan_prio_enc.sv
// Lowest-index priority encoder over the per-channel match vector.
// o_idx is 0 when no request is set.
module rvfi_chan_prio_enc
  import rvfi_sched_pkg::*;
#(
  parameter int N = 1,
  parameter int W = chan_idx_w(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scan high to low so the lowest set request is the last write.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/rvfi_check_scheduler.sv
// Sequences one RVFI check: hold the DUT in reset, let it run, then arm and
// strobe the checker on the retirement whose order matches the latched target.
module rvfi_check_scheduler
  import rvfi_sched_pkg::*;
#(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int RUN_CYCLES   = 10,
  parameter int MAX_WAIT     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ORDER_W-1:0]            target_order,
  input  logic [NRET-1:0]               rvfi_valid,
  input  logic [ORDER_W*NRET-1:0]       rvfi_order,
  output logic                          dut_reset,
  output logic                          check,
  output logic [chan_idx_w(NRET)-1:0]   check_chan,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout
);

  localparam int CHAN_W = chan_idx_w(NRET);

  sched_state_e         r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ORDER_W-1:0]   r_target;
  logic                 r_done;
  logic                 r_timeout;

  logic [NRET-1:0]      w_match;
  logic [CHAN_W-1:0]    w_idx;
  logic                 w_any;
  logic                 w_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NRET; gi++) begin : g_match
      assign w_match[gi] = rvfi_valid[gi] &&
                           (rvfi_order[CHAN_SLICE_W*gi +: CHAN_SLICE_W] == r_target);
    end
  endgenerate

  rvfi_chan_prio_enc #(
    .N (NRET),
    .W (CHAN_W)
  ) u_prio (
    .i_req (w_match),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_fire = (r_state == ST_ARM) && w_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_target  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_target  <= target_order;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= (RUN_CYCLES == 0) ? ST_ARM : ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_ARM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ARM: begin
          // A match on the last allowed cycle wins over the timeout.
          if (w_any) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_FIRE_DONE;
          end else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_FIRE_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIRE_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_reset  = reset || (r_state == ST_HOLD);
  assign check      = w_fire && !reset;
  assign check_chan = check ? w_idx : '0;
  assign busy       = !reset && (r_state != ST_IDLE);
  assign done       = !reset && r_done;
  assign timeout    = !reset && r_timeout;

endmodule
